// File: rtl/dual_issue_dispatch_if.sv
// dual_issue_dispatch_if
//   Bundles every decode-side, writeback and issue-side signal of the dual-issue
//   dispatch controller. Clock and reset stay outside as plain ports.
//   master : the environment (decode stage, writeback ports, pipeline control)
//   slave  : the dispatch controller itself
// Signals
//   i_flush, i_stall                         pipeline control
//   i_in_valid / o_in_ready                  decoded-pair handshake
//   i_slot_valid, i_src0/1, i_dst,
//   i_regwrite, i_memop                      per-slot decoded fields, slot k at [k*AREG_W +: AREG_W]
//   i_wb_valid, i_wb_addr                    two writeback ports
//   o_issue_*                                registered issue bundle
//   o_stall_cycles                           saturating blocked-cycle counter
interface dual_issue_dispatch_if #(
  parameter int AREG_W = 5,
  parameter int CNT_W  = 16
);
  logic                  i_flush;
  logic                  i_stall;
  logic                  i_in_valid;
  logic                  o_in_ready;
  logic [1:0]            i_slot_valid;
  logic [2*AREG_W-1:0]   i_src0;
  logic [2*AREG_W-1:0]   i_src1;
  logic [2*AREG_W-1:0]   i_dst;
  logic [1:0]            i_regwrite;
  logic [1:0]            i_memop;
  logic [1:0]            i_wb_valid;
  logic [2*AREG_W-1:0]   i_wb_addr;
  logic [1:0]            o_issue_valid;
  logic [2*AREG_W-1:0]   o_issue_src0;
  logic [2*AREG_W-1:0]   o_issue_src1;
  logic [2*AREG_W-1:0]   o_issue_dst;
  logic [1:0]            o_issue_regwrite;
  logic [1:0]            o_issue_memop;
  logic [CNT_W-1:0]      o_stall_cycles;

  modport master (
    output i_flush, i_stall, i_in_valid, i_slot_valid, i_src0, i_src1, i_dst,
           i_regwrite, i_memop, i_wb_valid, i_wb_addr,
    input  o_in_ready, o_issue_valid, o_issue_src0, o_issue_src1, o_issue_dst,
           o_issue_regwrite, o_issue_memop, o_stall_cycles
  );

  modport slave (
    input  i_flush, i_stall, i_in_valid, i_slot_valid, i_src0, i_src1, i_dst,
           i_regwrite, i_memop, i_wb_valid, i_wb_addr,
    output o_in_ready, o_issue_valid, o_issue_src0, o_issue_src1, o_issue_dst,
           o_issue_regwrite, o_issue_memop, o_stall_cycles
  );
endinterface

// File: rtl/dual_issue_dispatch.sv
// dual_issue_dispatch
//   In-order dispatch between dual-issue decode and execute. Holds one decoded
//   pair, tracks pending register writes in a scoreboard and issues 0/1/2
//   instructions per cycle, resolving RAW/WAW against in-flight writers,
//   intra-pair dependencies and the single memory port.
// Ports
//   i_clk, i_rst   clock, asynchronous active-high reset
//   bus (slave)    handshake, decoded fields, writebacks, issue outputs, stall counter
module dual_issue_dispatch #(
  parameter int NUM_AREGS = 32,
  parameter int AREG_W    = 5,
  parameter int CNT_W     = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  dual_issue_dispatch_if.slave  bus
);
  typedef enum logic [1:0] {S_EMPTY, S_PAIR, S_ONE} state_e;

  typedef struct packed {
    logic [AREG_W-1:0] src0;
    logic [AREG_W-1:0] src1;
    logic [AREG_W-1:0] dst;
    logic              rw;
    logic              mem;
  } slot_t;

  state_e                 state_q;
  slot_t [1:0]            buf_q;
  logic                   v1_q;
  logic [NUM_AREGS-1:0]   sb_q, sb_d;
  logic [CNT_W-1:0]       cnt_q;
  logic [1:0]             iss_vld_q;
  slot_t [1:0]            iss_q;

  slot_t [1:0]            in_slot;
  logic [1:0]             blk;
  logic [1:0]             iss;
  logic                   intra;

  genvar k;
  generate
    for (k = 0; k < 2; k++) begin : g_slot
      assign in_slot[k].src0 = bus.i_src0[k*AREG_W +: AREG_W];
      assign in_slot[k].src1 = bus.i_src1[k*AREG_W +: AREG_W];
      assign in_slot[k].dst  = bus.i_dst[k*AREG_W +: AREG_W];
      assign in_slot[k].rw   = bus.i_regwrite[k];
      assign in_slot[k].mem  = bus.i_memop[k];

      // Hazards are judged on the registered scoreboard only; a writeback
      // landing this cycle frees the entry on the next one.
      assign blk[k] = sb_q[buf_q[k].src0] | sb_q[buf_q[k].src1] |
                      (buf_q[k].rw & sb_q[buf_q[k].dst]);

      assign bus.o_issue_src0[k*AREG_W +: AREG_W] = iss_q[k].src0;
      assign bus.o_issue_src1[k*AREG_W +: AREG_W] = iss_q[k].src1;
      assign bus.o_issue_dst[k*AREG_W +: AREG_W]  = iss_q[k].dst;
      assign bus.o_issue_regwrite[k]              = iss_q[k].rw;
      assign bus.o_issue_memop[k]                 = iss_q[k].mem;
    end
  endgenerate

  // Younger slot may not read or overwrite what the older slot writes this cycle.
  assign intra = buf_q[0].rw & (buf_q[0].dst != '0) &
                 ((buf_q[0].dst == buf_q[1].src0) |
                  (buf_q[0].dst == buf_q[1].src1) |
                  (buf_q[0].dst == buf_q[1].dst));

  assign bus.o_in_ready     = (state_q == S_EMPTY) & ~bus.i_flush;
  assign bus.o_issue_valid  = iss_vld_q;
  assign bus.o_stall_cycles = cnt_q;

  always_comb begin
    iss = '0;
    if (!bus.i_flush && !bus.i_stall) begin
      unique case (state_q)
        S_PAIR: begin
          iss[0] = ~blk[0];
          iss[1] = ~blk[0] & v1_q & ~blk[1] & ~intra & ~(buf_q[0].mem & buf_q[1].mem);
        end
        // Only old slot 1 remains; it is now the oldest entry.
        S_ONE:   iss[1] = ~blk[1];
        default: iss    = '0;
      endcase
    end
  end

  // Clears first, then sets, so an issuing writer keeps its register pending
  // even if a stale writeback to it arrives on the same edge.
  always_comb begin
    sb_d = sb_q;
    for (int w = 0; w < 2; w++)
      if (bus.i_wb_valid[w]) sb_d[bus.i_wb_addr[w*AREG_W +: AREG_W]] = 1'b0;
    for (int s = 0; s < 2; s++)
      if (iss[s] && buf_q[s].rw && (buf_q[s].dst != '0)) sb_d[buf_q[s].dst] = 1'b1;
    sb_d[0] = 1'b0;
    if (bus.i_flush) sb_d = '0;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= S_EMPTY;
      buf_q     <= '0;
      v1_q      <= 1'b0;
      sb_q      <= '0;
      cnt_q     <= '0;
      iss_vld_q <= '0;
      iss_q     <= '0;
    end else begin
      sb_q      <= sb_d;
      iss_vld_q <= iss;
      for (int s = 0; s < 2; s++)
        if (iss[s]) iss_q[s] <= buf_q[s];

      if (!bus.i_flush && (state_q != S_EMPTY) && (iss == 2'b00) &&
          (cnt_q != {CNT_W{1'b1}}))
        cnt_q <= cnt_q + 1'b1;

      if (bus.i_flush) begin
        state_q <= S_EMPTY;
      end else begin
        unique case (state_q)
          S_EMPTY: begin
            if (bus.i_in_valid) begin
              buf_q <= in_slot;
              v1_q  <= bus.i_slot_valid[1];
              if (bus.i_slot_valid[0])      state_q <= S_PAIR;
              else if (bus.i_slot_valid[1]) state_q <= S_ONE;
            end
          end
          S_PAIR: begin
            if (iss[0]) state_q <= (v1_q && !iss[1]) ? S_ONE : S_EMPTY;
          end
          S_ONE: begin
            if (iss[1]) state_q <= S_EMPTY;
          end
          default: state_q <= S_EMPTY;
        endcase
      end
    end
  end
endmodule
